// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the core's instruction-fetch
//   port (i_*) and its load/store port (d_*). Only one transaction is
//   outstanding at a time. The FSM records which port owns it and routes
//   the memory response back to that port. Responses may take any number
//   of cycles. A new command may issue in the same cycle that the previous
//   response returns.
//
//   Handshake: a requester raises *_req with stable command fields and
//   holds them until *_gnt is high in a cycle. *_gnt marks acceptance in
//   that cycle, and m_en/m_* carry the command in that same cycle. The
//   memory answers each command with exactly one m_rvalid cycle, which the
//   arbiter forwards as a one-cycle *_rvalid pulse to the owner.
//
//   Ports
//     clk, rst               clock, asynchronous active-high reset
//     i_req/i_addr           fetch request in
//     i_gnt                  fetch request out
//     i_rvalid/i_rdata       fetch response out
//     d_req/d_we/d_be/d_addr/d_wdata   load/store request in
//     d_gnt                  load/store request out
//     d_rvalid/d_rdata       load/store response out (d_rdata=0 for stores)
//     m_en/m_we/m_be/m_addr/m_wdata    memory command out (0 when idle)
//     m_rvalid/m_rdata       memory response in
//     err                    sticky: a response arrived with nothing outstanding
//     state_dbg              current FSM state (0 IDLE, 1 BUSY_I, 2 BUSY_D)
//
//   Build option ARB_RR_EN: when defined, ties are settled round-robin
//   against last_gnt. When undefined, the data port always wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [DATA_W/8-1:0]   m_be,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_gnt;   // 0 = fetch, 1 = data
  logic   we_q;       // write flag of the outstanding data transaction
  logic   err_q;

  logic   can_issue;
  logic   d_wins_tie;
  logic   grant_i;
  logic   grant_d;
  logic   rsp;

  // Outputs are forced to 0 while rst is high, even though they are
  // combinational from the inputs.
  assign can_issue = ~rst & ((state == IDLE) | m_rvalid);
  assign rsp       = ~rst & m_rvalid;

`ifdef ARB_RR_EN
  assign d_wins_tie = ~last_gnt;
`else
  assign d_wins_tie = 1'b1;
`endif

  assign grant_d = can_issue & d_req & (~i_req | d_wins_tie);
  assign grant_i = can_issue & i_req & ~grant_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (m_rvalid && state != IDLE) state_nxt = IDLE;
    if (grant_i)                   state_nxt = BUSY_I;
    else if (grant_d)              state_nxt = BUSY_D;
  end

  // Output logic
  always_comb begin
    i_gnt    = grant_i;
    d_gnt    = grant_d;
    m_en     = grant_i | grant_d;
    m_we     = 1'b0;
    m_be     = '0;
    m_addr   = '0;
    m_wdata  = '0;
    if (grant_d) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (grant_i) begin
      m_be    = {(DATA_W/8){1'b1}};
      m_addr  = i_addr;
    end

    i_rvalid = rsp & (state == BUSY_I);
    d_rvalid = rsp & (state == BUSY_D);
    i_rdata  = i_rvalid ? m_rdata : '0;
    // Store completions return zero data, judged by the registered write flag.
    d_rdata  = (d_rvalid && !we_q) ? m_rdata : '0;
    err       = err_q;
    state_dbg = state;
  end

  // Bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (grant_d) begin
        last_gnt <= 1'b1;
        we_q     <= d_we;
      end else if (grant_i) begin
        last_gnt <= 1'b0;
        we_q     <= 1'b0;
      end
      if (m_rvalid && state == IDLE) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_en, m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              err;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_data;
  logic exp_d, prev_d;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err(err), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled 2 time units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_rvalid = 0; m_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // Reset: all outputs 0 even with requests and a response present
    tick();
    i_req = 1; d_req = 1; m_rvalid = 1; m_rdata = 32'hFFFF_FFFF;
    #2;
    check("rst_i_gnt", i_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_m_en", m_en, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, 0);
    tick();
    idle_inputs();
    rst = 0;

    // Fetch with 1-cycle memory
    tick();
    i_req = 1; i_addr = 32'h0;
    #2;
    check("f_i_gnt", i_gnt, 1);
    check("f_d_gnt", d_gnt, 0);
    check("f_m_en", m_en, 1);
    check("f_m_we", m_we, 0);
    check("f_m_be", m_be, 4'hF);
    check("f_m_addr", m_addr, 32'h0);
    tick();
    i_req = 0; m_rvalid = 1; m_rdata = 32'h0050_0093; exp_q.push_back(32'h0050_0093);
    #2;
    check("f_state_busy", state_dbg, 1);
    check("f_i_rvalid", i_rvalid, 1);
    exp_data = exp_q.pop_front();
    check("f_i_rdata", i_rdata, exp_data);
    check("f_d_rvalid", d_rvalid, 0);
    check("f_m_en_idle", m_en, 0);
    tick();
    m_rvalid = 0; m_rdata = '0;
    #2;
    check("f_state_idle", state_dbg, 0);
    check("f_i_rvalid_off", i_rvalid, 0);
    check("f_err", err, 0);

    // Store
    tick();
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    #2;
    check("st_d_gnt", d_gnt, 1);
    check("st_m_we", m_we, 1);
    check("st_m_addr", m_addr, 32'h100);
    check("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("st_m_be", m_be, 4'hF);
    tick();
    idle_inputs(); m_rvalid = 1; m_rdata = 32'h1234_5678;
    #2;
    check("st_state", state_dbg, 2);
    check("st_d_rvalid", d_rvalid, 1);
    check("st_d_rdata", d_rdata, 0);
    check("st_i_rvalid", i_rvalid, 0);

    // Load with partial byte enables
    tick();
    idle_inputs();
    d_req = 1; d_we = 0; d_be = 4'h3; d_addr = 32'h104; d_wdata = 32'h5555_5555;
    #2;
    check("ld_d_gnt", d_gnt, 1);
    check("ld_m_we", m_we, 0);
    check("ld_m_be", m_be, 4'h3);
    check("ld_m_addr", m_addr, 32'h104);
    tick();
    idle_inputs(); m_rvalid = 1; m_rdata = 32'hCAFE_F00D; exp_q.push_back(32'hCAFE_F00D);
    #2;
    check("ld_d_rvalid", d_rvalid, 1);
    exp_data = exp_q.pop_front();
    check("ld_d_rdata", d_rdata, exp_data);
    tick();
    idle_inputs();

    // Both ports requesting continuously, 1-cycle memory (loads)
    prev_d = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      i_req = 1; i_addr = 32'h200 + k * 4;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300 + k * 4;
      m_rvalid = (k > 0); m_rdata = 32'h1000 + k;
      #2;
`ifdef ARB_RR_EN
      exp_d = ((k % 2) == 1);
`else
      exp_d = 1'b1;
`endif
      check("tie_d_gnt", d_gnt, exp_d);
      check("tie_i_gnt", i_gnt, !exp_d);
      check("tie_m_addr", m_addr, exp_d ? 32'h300 + k * 4 : 32'h200 + k * 4);
      if (k > 0) begin
        check("tie_i_rvalid", i_rvalid, !prev_d);
        check("tie_d_rvalid", d_rvalid, prev_d);
        check("tie_rdata", prev_d ? d_rdata : i_rdata, 32'h1000 + k);
      end
      prev_d = exp_d;
    end
    tick();
    idle_inputs(); m_rvalid = 1; m_rdata = 32'h2000;
    #2;
    check("tie_last_rvalid", prev_d ? d_rvalid : i_rvalid, 1);
    check("tie_last_m_en", m_en, 0);
    tick();
    idle_inputs();

    // 3-cycle memory latency with a second request pending
    tick();
    i_req = 1; i_addr = 32'h40;
    #2;
    check("lat_i_gnt", i_gnt, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      i_req = 0; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h500;
      #2;
      check("lat_wait_d_gnt", d_gnt, 0);
      check("lat_wait_m_en", m_en, 0);
      check("lat_wait_i_rvalid", i_rvalid, 0);
    end
    tick();
    m_rvalid = 1; m_rdata = 32'hA5A5_0001; exp_q.push_back(32'hA5A5_0001);
    #2;
    check("lat_d_gnt", d_gnt, 1);
    check("lat_m_addr", m_addr, 32'h500);
    check("lat_i_rvalid", i_rvalid, 1);
    exp_data = exp_q.pop_front();
    check("lat_i_rdata", i_rdata, exp_data);
    tick();
    idle_inputs(); m_rvalid = 1; m_rdata = 32'h0BAD_CAFE;
    #2;
    check("lat_d_rvalid", d_rvalid, 1);
    check("lat_d_rdata", d_rdata, 32'h0BAD_CAFE);
    tick();
    idle_inputs();

    // Reset while BUSY_D, then a late response
    tick();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h600;
    #2;
    check("rb_d_gnt", d_gnt, 1);
    tick();
    idle_inputs(); rst = 1;
    #2;
    check("rb_state_rst", state_dbg, 0);
    check("rb_d_rvalid_rst", d_rvalid, 0);
    tick();
    rst = 0;
    #2;
    check("rb_err_clear", err, 0);
    tick();
    m_rvalid = 1; m_rdata = 32'h7777_7777;
    #2;
    check("rb_late_d_rvalid", d_rvalid, 0);
    check("rb_late_i_rvalid", i_rvalid, 0);
    tick();
    m_rvalid = 0;
    #2;
    check("rb_err_set", err, 1);
    // Normal fetch afterwards; err stays set
    tick();
    i_req = 1; i_addr = 32'h80;
    #2;
    check("rb_i_gnt", i_gnt, 1);
    tick();
    i_req = 0; m_rvalid = 1; m_rdata = 32'h1;
    #2;
    check("rb_i_rvalid", i_rvalid, 1);
    tick();
    m_rvalid = 0;
    #2;
    check("rb_err_sticky", err, 1);
    tick();
    rst = 1;
    #2;
    check("rb_err_reset", err, 0);
    tick();
    rst = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's instruction-fetch port and load/store data port onto a single shared memory port, so one single-ported instruction/data RAM can serve both. It sits inside `top` between `core` and the memory model. It issues one memory transaction at a time, tracks which requester owns the outstanding transaction, and routes the response back to that owner. Responses may take any number of cycles.

## Interface
Parameters:
- `ADDR_W`, 32, address width in bits.
- `DATA_W`, 32, data width in bits; byte-enable width is `DATA_W/8`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch request; held until `i_gnt`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_gnt`  out  1  fetch request accepted this cycle.
- `i_rvalid`  out  1  fetch data valid (one-cycle pulse).
- `i_rdata`  out  DATA_W  fetch data.
- `d_req`  in  1  load/store request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  DATA_W/8  store byte enables.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid, or store completed (one-cycle pulse).
- `d_rdata`  out  DATA_W  load data; 0 on store completion.
- `m_en`  out  1  memory transaction issued this cycle.
- `m_we`, `m_be`, `m_addr`, `m_wdata`  out  1 / DATA_W/8 / ADDR_W / DATA_W  issued command fields.
- `m_rvalid`  in  1  memory response for the outstanding transaction.
- `m_rdata`  in  DATA_W  memory read data.
- `err`  out  1  sticky: a `m_rvalid` arrived with no transaction outstanding.

## Operation
- The FSM has three states:
  - `IDLE`: nothing outstanding.
  - `BUSY_I`: a fetch is outstanding.
  - `BUSY_D`: a load/store is outstanding.
- Issue condition: `can_issue = (state==IDLE) | m_rvalid`. A new transaction may therefore issue in the same cycle the previous response returns.
- Selection when `can_issue`:
  - Only one request present: that request wins.
  - Both present: the policy from Configuration decides.
  - The winner's `gnt` goes high and `m_en=1`.
  - `m_we`, `m_be`, `m_addr`, `m_wdata` are muxed from the winner.
  - Fetch issues always drive `m_we=0` and `m_be` all-ones.
- State after the edge:
  - Granted fetch: `BUSY_I`.
  - Granted data: `BUSY_D`.
  - Response with no new grant: `IDLE`.
- Routing of `m_rvalid`:
  - In `BUSY_I`: `i_rvalid=1`, `i_rdata=m_rdata`.
  - In `BUSY_D`: `d_rvalid=1`. `d_rdata=m_rdata` for a load; `d_rdata=0` for a store, using the registered `we` of the outstanding transaction.
  - In `IDLE`: the response is ignored and `err` is set.
- When no transaction issues, the `m_*` command fields are driven to 0.
- `last_gnt` register: records the port of the most recent grant, 0 = I, 1 = D.

## Timing
- `gnt`, `m_*` command outputs and `*_rvalid`/`*_rdata` are combinational from the current state and inputs; there is no registered output latency.
- Minimum request-to-response time is 1 cycle: grant in cycle N, `m_rvalid` in cycle N+1.
- Back-to-back throughput is one transaction per cycle when memory responds in 1 cycle.
- Values during and after reset: state `IDLE`, `last_gnt=1`, `err=0`. All outputs are 0 while `rst` is high. After reset, a tie grants I first.
- Reset mid-transaction: the outstanding transaction is abandoned and no `rvalid` is generated. A late `m_rvalid` after reset sets `err`.
- A request that is dropped before `gnt` is not an error; it is simply never issued.
- A `m_rvalid` in the same cycle as a new issue returns the old response and issues the new command.

## Configuration
- `ARB_RR_EN` defined: round-robin. On a tie, grant the port other than `last_gnt`.
- `ARB_RR_EN` undefined: fixed priority, data port always wins ties. `last_gnt` is still maintained but unused. Fetch can starve only while `d_req` is continuously asserted.

## Test plan
- Reset, then `i_req=1`, `i_addr=0x0`, memory replies next cycle with `0x00500093` -> `i_gnt` in cycle 1, `i_rvalid=1` and `i_rdata=0x00500093` in cycle 2, state returns to `IDLE`.
- Store `d_addr=0x100`, `d_wdata=0xDEADBEEF`, `d_be=0xF` -> `m_we=1`, `m_addr=0x100`; `d_rvalid=1` and `d_rdata=0` on the response.
- Both requesting continuously, 1-cycle memory:
  - With `ARB_RR_EN`: grants alternate I, D, I, D…
  - Without it: D granted every cycle and `i_gnt` stays 0.
- Memory latency of 3 cycles, second request pending -> no second `gnt` until the cycle `m_rvalid=1`; in that cycle the second grant and the first response occur together.
- Assert `rst` while in `BUSY_D`, then pulse `m_rvalid` after release -> no `d_rvalid`, `err=1` and sticky until the next reset.
